// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop processes one
// operand bit per clock, then publishes the parallel sum/carry-out atomically.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sbit,
  output logic             sbit_valid,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Full adder built from two half-adder stages and a carry OR.
  logic w_ha1_s;
  logic w_ha1_c;
  logic w_ha2_s;
  logic w_ha2_c;
  logic w_s;
  logic w_c;
  logic [WIDTH-1:0] w_acc_next;
  logic w_run;

  assign w_ha1_s = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha1_c = r_a_sh[0] & r_b_sh[0];
  assign w_ha2_s = w_ha1_s ^ r_carry;
  assign w_ha2_c = w_ha1_s & r_carry;
  assign w_s     = w_ha2_s;
  assign w_c     = w_ha1_c | w_ha2_c;

  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_next = w_s;
    end else begin : g_acc_wn
      assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          // Sum/cout are only written here, so partial results never leak out.
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_run      = (r_state == S_RUN);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign sum        = r_sum;
  assign cout       = r_cout;
  assign sbit_valid = w_run;
  assign sbit       = w_run & w_s;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: cycle-indexed driver with an arithmetic reference model,
// and a negedge monitor that pops expected results from a scoreboard queue.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sbit;
  logic             sbit_valid;
  logic [1:0]       state_dbg;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;
  logic       sbit1;
  logic       sbit_valid1;
  logic [1:0] state_dbg1;

  serial_adder #(.WIDTH(WIDTH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .sbit(sbit), .sbit_valid(sbit_valid), .state_dbg(state_dbg)
  );

  serial_adder #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .sbit(sbit1), .sbit_valid(sbit_valid1), .state_dbg(state_dbg1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: {cout,sum} expected per accepted op, plus the accept edges
  // of the two most recent ops (an op spans edges n..n+WIDTH, IDLE follows).
  logic [WIDTH:0] exp_q[$];
  int last_n = -1000;
  int prev_n = -1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_op(input int n, input int c);
    return (c >= n) && (c <= n + WIDTH);
  endfunction

  function automatic bit in_run(input int n, input int c);
    return (c >= n) && (c <= n + WIDTH - 1);
  endfunction

  // Driver tasks: inputs change 2 time units after the active edge.
  task automatic step(input logic st, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vc);
    logic [WIDTH:0] t;
    start = st;
    a     = va;
    b     = vb;
    cin   = vc;
    // Start is only honoured in IDLE, i.e. from WIDTH+2 edges after the last accept.
    if (st && (cyc + 1 >= last_n + WIDTH + 2)) begin
      t = {1'b0, va};
      t = t + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
      exp_q.push_back(t);
      prev_n = last_n;
      last_n = cyc + 1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, b, cin);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_n = -1000;
    prev_n = -1000;
  endtask

  // Monitor / scoreboard
  logic [WIDTH-1:0] mon_ser;
  int               mon_nb;
  logic [WIDTH:0]   mon_last;
  logic [WIDTH:0]   mon_exp;

  initial begin
    mon_ser  = '0;
    mon_nb   = 0;
    mon_last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_ser  = '0;
        mon_nb   = 0;
        mon_last = '0;
      end else begin
        check("busy", busy, in_op(prev_n, cyc) || in_op(last_n, cyc));
        check("done", done, (cyc == prev_n + WIDTH) || (cyc == last_n + WIDTH));
        check("sbit_valid", sbit_valid, in_run(prev_n, cyc) || in_run(last_n, cyc));
        if (sbit_valid) begin
          mon_ser = {sbit, mon_ser[WIDTH-1:1]};
          mon_nb++;
        end else begin
          check("sbit_idle", sbit, 0);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
          end else begin
            mon_exp = exp_q.pop_front();
            check("result", {cout, sum}, mon_exp);
            check("serial_stream", mon_ser, mon_exp[WIDTH-1:0]);
            check("serial_bits", mon_nb, WIDTH);
            mon_last = mon_exp;
          end
          mon_nb = 0;
        end else begin
          check("result_hold", {cout, sum}, mon_last);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    check("reset_outputs", {busy, done, sum, cout, sbit, sbit_valid, state_dbg}, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();

    // Basic add and serial stream
    step(1'b1, 8'h5A, 8'h3C, 1'b0);
    idle(10);
    // Carry-out boundaries
    step(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(10);
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    idle(10);
    // Operand change and start pulse during RUN are ignored
    step(1'b1, 8'h01, 8'h01, 1'b0);
    step(1'b0, 8'h01, 8'h01, 1'b0);
    step(1'b0, 8'h77, 8'h01, 1'b0);
    step(1'b1, 8'h10, 8'h01, 1'b0);
    idle(10);
    // Start held high: back-to-back ops, one IDLE cycle between them
    for (int i = 0; i < 30; i++) step(1'b1, 8'h0F, 8'h01, 1'b0);
    idle(12);
    // Reset mid-operation discards the op and clears the previous result
    step(1'b1, 8'h5A, 8'h3C, 1'b0);
    idle(10);
    step(1'b1, 8'h22, 8'h11, 1'b0);
    idle(3);
    rst = 1'b1;
    #1;
    check("mid_op_reset", {busy, done, sum, cout, sbit, sbit_valid, state_dbg}, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1'b1, 8'h22, 8'h11, 1'b0);
    idle(10);

    // Single-bit build
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk);
    #2;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(negedge clk);
    check("w1_run", {busy1, done1, sbit_valid1, sbit1}, 4'b1011);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("w1_done", {busy1, done1, sbit_valid1, cout1, sum1}, 5'b11011);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("w1_idle", {busy1, done1, cout1, sum1}, 4'b0011);

    // Randomized traffic with start pulses and operand changes at any time
    for (int i = 0; i < 400; i++) begin
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '1;
      step($urandom_range(0, 2) == 0, ra, rb, 1'($urandom_range(0, 1)));
    end
    idle(12);
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
